dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: word-aligned byte address width of the shared data-memory port.
REQ-002 Parameter MAX_STARVE, default 4: consecutive requester-0 grants allowed while requester 1 waits; legal range 1..15.
REQ-003 clk_i  in  1  single clock, rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 req_vld_i  in  2  request valid; bit 0 = core LSU, bit 1 = debug loader.
REQ-006 req_rdy_o  out  2  request accepted this cycle (one-hot or zero).
REQ-007 req_we_i  in  2  1 = write, 0 = read, per requester.
REQ-008 req_addr_i  in  2xADDR_WIDTH  byte address per requester.
REQ-009 req_wdata_i  in  2x32  write data per requester.
REQ-010 req_wstrb_i  in  2x4  byte strobes per requester.
REQ-011 rsp_vld_o  out  2  response valid, one cycle after accept.
REQ-012 rsp_rdata_o  out  32  read data; shared, qualified by rsp_vld_o.
REQ-013 mem_en_o, mem_we_o  out  1 each  memory access strobe and write enable.
REQ-014 mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  32; mem_wstrb_o  out  4.
REQ-015 mem_rdata_i  in  32  read data, valid exactly one cycle after mem_en_o.
REQ-016 grant_cnt0_o, grant_cnt1_o  out  16 each  statistics counters (see Configuration).

Function
REQ-017 Handshake: a transfer occurs when req_vld_i[k] and req_rdy_o[k] are both high; requests shall hold stable until accepted.
REQ-018 At most one request shall be accepted per cycle; back-to-back acceptance every cycle shall be supported.
REQ-019 Grant logic is combinational from req_vld_i and the registered state; mem_* outputs mirror the selected request in the accept cycle; mem_en_o is low when nothing is accepted.
REQ-020 FSM states PRIO0 and FORCE1; reset state PRIO0.
REQ-021 PRIO0: requester 0 wins when it is valid; otherwise requester 1 wins when it is valid.
REQ-022 4-bit starve counter: increments when requester 0 is granted while req_vld_i[1] is high; clears on any requester-1 grant or whenever req_vld_i[1] is low.
REQ-023 On the grant that brings the counter to MAX_STARVE, the FSM shall enter FORCE1 in the next cycle.
REQ-024 FORCE1: requester 1 wins unconditionally; after its grant, return to PRIO0 with the counter cleared. If req_vld_i[1] drops, return to PRIO0 with no grant that cycle.
REQ-025 Response: a one-stage tag register records the owner and we of the accepted request; in the next cycle, rsp_vld_o[owner]=1 for both reads and writes; rsp_rdata_o=mem_rdata_i for reads, 0 for writes.
REQ-026 A new accept and a previous response in the same cycle shall both occur, with no bubble.

Reset
REQ-027 While rst_i is high: req_rdy_o=0, rsp_vld_o=0, rsp_rdata_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o, mem_wdata_o and mem_wstrb_o all 0, FSM=PRIO0, starve counter=0, grant counters=0.
REQ-028 A reset asserted mid-transaction shall discard the in-flight response; no rsp_vld_o pulse occurs after reset release.

Configuration
REQ-029 Macro DMEM_ARB_STATS_EN defined: grant_cntk_o counts grants to requester k, saturating at 16'hFFFF.
REQ-030 Macro DMEM_ARB_STATS_EN undefined: grant_cnt0_o and grant_cnt1_o are tied to 0, with no counter flops.

Structure
REQ-031 Package dmem_arb_pkg holds the arb_state_e enum (PRIO0, FORCE1), the REQ_CORE=0 and REQ_DBG=1 index constants, and the WSTRB_W=4 and DATA_W=32 constants.
REQ-032 Sub-module dmem_arb_grant is combinational grant selection; the FSM, counters and tag register stay in the top level.

Verification
REQ-033 Only req0 is valid, with read addr 0x0010 and mem_rdata_i=0xDEADBEEF -> req_rdy_o=01 in cycle N; rsp_vld_o=01 and rsp_rdata_o=0xDEADBEEF in cycle N+1.
REQ-034 Both requesters are held valid continuously with MAX_STARVE=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1...
REQ-035 req1 writes alone with wstrb=4'b0011 -> mem_we_o=1, mem_wstrb_o=0011; rsp_vld_o=10 and rsp_rdata_o=0 in the next cycle.
REQ-036 req0 read accepted, then req1 read accepted the following cycle -> rsp_vld_o=01 coincides with req_rdy_o=10, then rsp_vld_o=10.
REQ-037 rst_i is asserted in the cycle after an accept -> no rsp_vld_o pulse; all outputs 0; after release the FSM is in PRIO0.
REQ-038 With DMEM_ARB_STATS_EN defined, 70000 req0 grants -> grant_cnt0_o=0xFFFF; undefined -> counters stay 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      PRIO0  = 1'b0,
      FORCE1 = 1'b1
   } arb_state_e;

   localparam int unsigned REQ_CORE = 0;
   localparam int unsigned REQ_DBG  = 1;
   localparam int unsigned WSTRB_W  = 4;
   localparam int unsigned DATA_W   = 32;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant selection: core-first in PRIO0, debug loader only in FORCE1.
module dmem_arb_grant
   import dmem_arb_pkg::*;
(
   input  arb_state_e state_i,
   input  logic [1:0] req_vld_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      unique case (state_i)
         PRIO0: begin
            if (req_vld_i[REQ_CORE]) begin
               gnt_o[REQ_CORE] = 1'b1;
            end else if (req_vld_i[REQ_DBG]) begin
               gnt_o[REQ_DBG] = 1'b1;
            end
         end
         FORCE1: gnt_o[REQ_DBG] = req_vld_i[REQ_DBG];
         default: gnt_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with starvation guard and one-stage response tag.
// Optional grant statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_STARVE = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [1:0]                       req_vld_i,
   output logic [1:0]                       req_rdy_o,
   input  logic [1:0]                       req_we_i,
   input  logic [1:0][ADDR_WIDTH-1:0]       req_addr_i,
   input  logic [1:0][DATA_W-1:0]           req_wdata_i,
   input  logic [1:0][WSTRB_W-1:0]          req_wstrb_i,
   output logic [1:0]                       rsp_vld_o,
   output logic [DATA_W-1:0]                rsp_rdata_o,
   output logic                             mem_en_o,
   output logic                             mem_we_o,
   output logic [ADDR_WIDTH-1:0]            mem_addr_o,
   output logic [DATA_W-1:0]                mem_wdata_o,
   output logic [WSTRB_W-1:0]               mem_wstrb_o,
   input  logic [DATA_W-1:0]                mem_rdata_i,
   output logic [15:0]                      grant_cnt0_o,
   output logic [15:0]                      grant_cnt1_o
);

   localparam logic [3:0] MaxStarve = 4'(MAX_STARVE);

   arb_state_e state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic [1:0] gnt_raw, gnt;
   logic       sel;
   logic       tag_vld_q, tag_owner_q, tag_we_q;

   dmem_arb_grant u_grant (
      .state_i   (state_q),
      .req_vld_i (req_vld_i),
      .gnt_o     (gnt_raw)
   );

   // Reset forces the combinational accept path quiet as well as the flops.
   assign gnt = rst_i ? 2'b00 : gnt_raw;
   assign sel = gnt[REQ_DBG];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= PRIO0;
         starve_q    <= '0;
         tag_vld_q   <= 1'b0;
         tag_owner_q <= 1'b0;
         tag_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tag_vld_q   <= |gnt;
         tag_owner_q <= sel;
         tag_we_q    <= req_we_i[sel];
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (gnt[REQ_DBG] || !req_vld_i[REQ_DBG]) begin
         starve_d = '0;
      end else if (gnt[REQ_CORE]) begin
         starve_d = starve_q + 4'd1;
      end
      unique case (state_q)
         PRIO0: begin
            if (gnt[REQ_CORE] && req_vld_i[REQ_DBG] && (starve_q + 4'd1 == MaxStarve)) begin
               state_d = FORCE1;
            end
         end
         FORCE1: begin
            if (gnt[REQ_DBG] || !req_vld_i[REQ_DBG]) begin
               state_d = PRIO0;
            end
         end
         default: state_d = PRIO0;
      endcase
   end

   always_comb begin
      req_rdy_o   = gnt;
      mem_en_o    = |gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wstrb_o = '0;
      if (|gnt) begin
         mem_we_o    = req_we_i[sel];
         mem_addr_o  = req_addr_i[sel];
         mem_wdata_o = req_wdata_i[sel];
         mem_wstrb_o = req_wstrb_i[sel];
      end
      rsp_vld_o = '0;
      if (tag_vld_q) begin
         rsp_vld_o[tag_owner_q] = 1'b1;
      end
      rsp_rdata_o = (tag_vld_q && !tag_we_q) ? mem_rdata_i : '0;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt[REQ_CORE] && (cnt0_q != 16'hFFFF)) begin
            cnt0_q <= cnt0_q + 16'd1;
         end
         if (gnt[REQ_DBG] && (cnt1_q != 16'hFFFF)) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
      end
   end

   assign grant_cnt0_o = cnt0_q;
   assign grant_cnt1_o = cnt1_q;
`else
   assign grant_cnt0_o = '0;
   assign grant_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default parameters).
module tb_dmem_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_vld;
   logic [1:0]        req_rdy;
   logic [1:0]        req_we;
   logic [1:0][15:0]  req_addr;
   logic [1:0][31:0]  req_wdata;
   logic [1:0][3:0]   req_wstrb;
   logic [1:0]        rsp_vld;
   logic [31:0]       rsp_rdata;
   logic              mem_en, mem_we;
   logic [15:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_rdata;
   logic [15:0]       grant_cnt0, grant_cnt1;

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(
      .ADDR_WIDTH (16),
      .MAX_STARVE (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_vld_i    (req_vld),
      .req_rdy_o    (req_rdy),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_wstrb_i  (req_wstrb),
      .rsp_vld_o    (rsp_vld),
      .rsp_rdata_o  (rsp_rdata),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_wstrb_o  (mem_wstrb),
      .mem_rdata_i  (mem_rdata),
      .grant_cnt0_o (grant_cnt0),
      .grant_cnt1_o (grant_cnt1)
   );

   always #5 clk = ~clk;

   // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_vld   = 2'b11;
      req_we    = 2'b11;
      req_addr  = {16'h1234, 16'h5678};
      req_wdata = {32'h1111_2222, 32'h3333_4444};
      req_wstrb = {4'hF, 4'hF};
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      #1;
      checks++;
      if (req_rdy !== 2'b00 || rsp_vld !== 2'b00 || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_hs rdy=%b rsp_vld=%b rdata=%h required 00/00/0", req_rdy, rsp_vld, rsp_rdata);
      end
      checks++;
      if ({mem_en, mem_we} !== 2'b00 || mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         errors++;
         $display("FAIL reset_mem en=%b we=%b addr=%h wdata=%h wstrb=%h required all 0",
                  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      checks++;
      if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_cnt cnt0=%h cnt1=%h required 0/0", grant_cnt0, grant_cnt1);
      end
      req_vld = 2'b00;
      req_we  = 2'b00;
      rst     = 1'b0;
      tick();
   endtask

   task automatic test_read0();
      req_vld      = 2'b01;
      req_we       = 2'b00;
      req_addr[0]  = 16'h0010;
      #1;
      checks++;
      if (req_rdy !== 2'b01 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
         errors++;
         $display("FAIL read0_accept rdy=%b en=%b we=%b addr=%h required 01/1/0/0010",
                  req_rdy, mem_en, mem_we, mem_addr);
      end
      tick();
      req_vld   = 2'b00;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (rsp_vld !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read0_rsp rsp_vld=%b rdata=%h required 01/deadbeef", rsp_vld, rsp_rdata);
      end
      checks++;
      if (req_rdy !== 2'b00 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_accept rdy=%b en=%b required 00/0", req_rdy, mem_en);
      end
      tick();
   endtask

   task automatic test_write1();
      req_vld      = 2'b10;
      req_we       = 2'b10;
      req_addr[1]  = 16'h0020;
      req_wdata[1] = 32'h1234_5678;
      req_wstrb[1] = 4'b0011;
      #1;
      checks++;
      if (req_rdy !== 2'b10 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 ||
          mem_wdata !== 32'h1234_5678 || mem_addr !== 16'h0020) begin
         errors++;
         $display("FAIL write1_accept rdy=%b we=%b wstrb=%b wdata=%h addr=%h required 10/1/0011/12345678/0020",
                  req_rdy, mem_we, mem_wstrb, mem_wdata, mem_addr);
      end
      tick();
      req_vld   = 2'b00;
      req_we    = 2'b00;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (rsp_vld !== 2'b10 || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL write1_rsp rsp_vld=%b rdata=%h required 10/0", rsp_vld, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      req_vld     = 2'b01;
      req_we      = 2'b00;
      req_addr[0] = 16'h0040;
      req_addr[1] = 16'h0080;
      #1;
      checks++;
      if (req_rdy !== 2'b01) begin
         errors++;
         $display("FAIL b2b_first rdy=%b required 01", req_rdy);
      end
      tick();
      req_vld   = 2'b10;
      mem_rdata = 32'hAAAA_0001;
      #1;
      checks++;
      if (rsp_vld !== 2'b01 || rsp_rdata !== 32'hAAAA_0001 || req_rdy !== 2'b10 || mem_addr !== 16'h0080) begin
         errors++;
         $display("FAIL b2b_overlap rsp_vld=%b rdata=%h rdy=%b addr=%h required 01/aaaa0001/10/0080",
                  rsp_vld, rsp_rdata, req_rdy, mem_addr);
      end
      tick();
      req_vld   = 2'b00;
      mem_rdata = 32'hBBBB_0002;
      #1;
      checks++;
      if (rsp_vld !== 2'b10 || rsp_rdata !== 32'hBBBB_0002) begin
         errors++;
         $display("FAIL b2b_second rsp_vld=%b rdata=%h required 10/bbbb0002", rsp_vld, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_starve();
      logic [1:0]  exp_pat [10];
      logic [15:0] exp_addr;
      exp_pat     = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      req_addr[0] = 16'h0100;
      req_addr[1] = 16'h0200;
      req_we      = 2'b00;
      for (int i = 0; i < 10; i++) begin
         req_vld = 2'b11;
         #1;
         exp_addr = (exp_pat[i] == 2'b10) ? 16'h0200 : 16'h0100;
         checks++;
         if (req_rdy !== exp_pat[i] || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL starve_pat[%0d] rdy=%b addr=%h required %b/%h", i, req_rdy, mem_addr,
                     exp_pat[i], exp_addr);
         end
         tick();
      end
      // Drive into FORCE1, then withdraw requester 1: no grant that cycle.
      for (int i = 0; i < 4; i++) begin
         req_vld = 2'b11;
         tick();
      end
      req_vld = 2'b01;
      #1;
      checks++;
      if (req_rdy !== 2'b00 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL force1_drop rdy=%b en=%b required 00/0", req_rdy, mem_en);
      end
      tick();
      #1;
      checks++;
      if (req_rdy !== 2'b01) begin
         errors++;
         $display("FAIL force1_return rdy=%b required 01", req_rdy);
      end
      tick();
      req_vld = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_pat [5];
      exp_pat   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      req_we    = 2'b11;
      req_wdata = {32'h5555_6666, 32'h7777_8888};
      req_wstrb = {4'hF, 4'hF};
      for (int i = 0; i < 4; i++) begin
         req_vld = 2'b11;
         tick();
      end
      // FSM is now in FORCE1 with a response outstanding.
      rst       = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      #1;
      checks++;
      if (rsp_vld !== 2'b00 || rsp_rdata !== 32'h0 || req_rdy !== 2'b00) begin
         errors++;
         $display("FAIL midrst_rsp rsp_vld=%b rdata=%h rdy=%b required 00/0/00", rsp_vld, rsp_rdata, req_rdy);
      end
      checks++;
      if ({mem_en, mem_we} !== 2'b00 || mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         errors++;
         $display("FAIL midrst_mem en=%b we=%b addr=%h wdata=%h wstrb=%h required all 0",
                  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (rsp_vld !== 2'b00) begin
         errors++;
         $display("FAIL midrst_no_pulse rsp_vld=%b required 00", rsp_vld);
      end
      for (int i = 0; i < 5; i++) begin
         req_vld = 2'b11;
         #1;
         checks++;
         if (req_rdy !== exp_pat[i]) begin
            errors++;
            $display("FAIL midrst_prio0[%0d] rdy=%b required %b", i, req_rdy, exp_pat[i]);
         end
         tick();
      end
      req_vld = 2'b00;
      req_we  = 2'b00;
      tick();
   endtask

   task automatic test_stats();
`ifdef DMEM_ARB_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL stats_clear cnt0=%h cnt1=%h required 0/0", grant_cnt0, grant_cnt1);
      end
      req_vld = 2'b01;
      for (int i = 0; i < 70000; i++) begin
         tick();
      end
      req_vld = 2'b00;
      tick();
      checks++;
      if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL stats_sat cnt0=%h cnt1=%h required ffff/0", grant_cnt0, grant_cnt1);
      end
`else
      #1;
      checks++;
      if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL stats_off cnt0=%h cnt1=%h required 0/0", grant_cnt0, grant_cnt1);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_read0();
      test_write1();
      test_back_to_back();
      test_starve();
      test_reset_mid();
      test_stats();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
